wb_master_arb: RTL and testbench
================================

# wb_master_arb

Two-master Wishbone classic arbiter that shares the single main system bus (the one feeding the `nic` address decoder, TCM and UART) between the `rv_core` instruction/data port (master 0) and a second bus master such as a debug loader or DMA (master 1). Grants are cycle-locked: a master owns the bus from `cyc` rise to `cyc` fall. Contention is resolved round-robin. A per-tenure watchdog terminates stalled transfers with an error strobe so an unmapped or hung slave cannot lock up the bus.

## Interface
- `TIMEOUT_CYCLES`, default 255: consecutive `stb`-without-`ack` cycles before error; 0 disables the watchdog.
- `i_clk`  in  1  system clock, all logic on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_m0_adr` / `i_m1_adr`  in  32  master address
- `i_m0_dat` / `i_m1_dat`  in  32  master write data
- `o_m0_dat` / `o_m1_dat`  out  32  read data, both driven directly from `i_wb_dat`
- `i_m0_we` / `i_m1_we`  in  1  write enable
- `i_m0_sel` / `i_m1_sel`  in  4  byte select
- `i_m0_stb` / `i_m1_stb`  in  1  strobe
- `i_m0_cyc` / `i_m1_cyc`  in  1  cycle / bus request
- `o_m0_ack` / `o_m1_ack`  out  1  acknowledge, gated by grant
- `o_m0_err` / `o_m1_err`  out  1  watchdog error, one-cycle pulse
- `o_wb_adr`  out  32, `o_wb_dat`  out  32, `o_wb_we`  out  1, `o_wb_sel`  out  4, `o_wb_stb`  out  1, `o_wb_cyc`  out  1: shared bus to the slave side
- `i_wb_dat`  in  32, `i_wb_ack`  in  1: slave response after NIC mux
- `o_grant`  out  2  one-hot current owner; `2'b00` when idle
- `o_timeout`  out  1  one-cycle pulse on any watchdog expiry

## Operation
- FSM states: IDLE, GNT0, GNT1. Registers: state, `r_last` (last granted master), watchdog counter of width `$clog2(TIMEOUT_CYCLES+1)`.
- **IDLE**
  - Only `i_m0_cyc` high: go to GNT0.
  - Only `i_m1_cyc` high: go to GNT1.
  - Both high: grant the master that is not `r_last`.
  - Neither high: stay in IDLE.
  - On entering GNTn, set `r_last <= n`.
- **GNTn**
  - Shared outputs are a combinational mux of master n: `adr`, `dat`, `we`, `sel`, `stb`, `cyc`.
  - `o_mn_ack = i_wb_ack`. The other master's ack and err are 0.
  - Leave for IDLE when `i_mn_cyc` is 0. The other master's request is never honoured directly from GNTn.
- **IDLE bus outputs:** `o_wb_cyc`, `o_wb_stb`, `o_wb_we` are 0; `o_wb_adr`, `o_wb_dat`, `o_wb_sel` are 0; all master acks and errs are 0.
- **Watchdog** (active only when `TIMEOUT_CYCLES` ≠ 0):
  - Clears to 0 in IDLE, on any cycle with `i_wb_ack`, and on any cycle with the granted `stb` low.
  - Otherwise increments.
  - When the counter equals `TIMEOUT_CYCLES-1` and `i_wb_ack` is low: pulse `o_mn_err` and `o_timeout` that cycle, and clear the counter.
  - The granted master must treat err as a terminated transfer. Cyc lock is kept; the master releases the bus by dropping cyc.
- If `i_wb_ack` and expiry coincide, ack wins: no err, counter clears.
- `o_mN_dat` is never gated. Masters qualify read data with their own ack.

## Timing
- **Reset values:** state IDLE, `r_last = 1` (so master 0 wins the first contention), counter 0. `o_grant = 0`, `o_timeout = 0`, all acks, errs and bus control outputs 0.
- **Arbitration latency:** with cyc rising at edge k and the FSM in IDLE, the grant register is set at edge k+1. Bus outputs follow master n from cycle k+1, so the first possible ack is in cycle k+1 for a zero-wait slave.
- **Release:** with cyc falling at edge k, the FSM is in IDLE from k+1. There is at least one IDLE turnaround cycle between tenures, which also forms the back-to-back handoff to a waiting master.
- Acks are combinational pass-through. There is no added latency inside a tenure, and pipelined back-to-back strobes within one cyc are allowed.
- Watchdog expiry occurs on the `TIMEOUT_CYCLES`-th consecutive unacked `stb` cycle, counting the first strobe cycle as 1.
- Reset asserted mid-tenure: next edge forces IDLE and reset values regardless of cyc or ack, and the counter clears.

## Test plan
- **Single master:** m0 raises cyc+stb, write `adr=0x0000_0010`, `dat=0xDEADBEEF`, slave acks 1 cycle later → `o_wb_*` mirror m0 from the grant cycle, `o_grant=01`, `o_m0_ack` 1 cycle, `o_m1_ack=0`; IDLE after cyc drops.
- **Contention after reset:** m0 and m1 raise cyc in the same cycle → m0 granted first. After m0 releases, m1 is granted after exactly one IDLE cycle. Repeating simultaneous requests alternates 1→0→1.
- **Cycle lock:** m0 holds cyc across 3 strobes while m1 requests → m1 stays ungranted with ack 0 until m0 drops cyc. All 3 m0 acks pass through.
- **Watchdog:** `TIMEOUT_CYCLES=4`, m1 strobes `adr=0xF000_0000` and the slave never acks → `o_m1_err` and `o_timeout` pulse on the 4th strobe cycle. Counter restarts, and a second pulse follows 4 cycles later if stb is held.
- **Ack on expiry cycle:** slave acks on exactly the 4th cycle → ack seen, no err. With `TIMEOUT_CYCLES=0` and no ack for 1000 cycles → no err.
- **Reset mid-transfer:** assert `i_reset` while GNT1 with stb high → next cycle `o_grant=00`, all bus outputs 0. After release, pending simultaneous requests grant m0 first.

Source files
------------

// File: rtl/wb_master_arb.sv
// Two-master Wishbone classic arbiter with cycle-locked round-robin grants
// and a per-tenure stall watchdog that terminates unacked strobes with err.
//
// state | meaning
// IDLE  | no owner; bus outputs quiet; arbitrate pending cyc requests
// GNT0  | master 0 owns the bus until it drops cyc
// GNT1  | master 1 owns the bus until it drops cyc
module wb_master_arb #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_m0_adr,
   input  logic [31:0] i_m0_dat,
   output logic [31:0] o_m0_dat,
   input  logic        i_m0_we,
   input  logic [3:0]  i_m0_sel,
   input  logic        i_m0_stb,
   input  logic        i_m0_cyc,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   input  logic [31:0] i_m1_adr,
   input  logic [31:0] i_m1_dat,
   output logic [31:0] o_m1_dat,
   input  logic        i_m1_we,
   input  logic [3:0]  i_m1_sel,
   input  logic        i_m1_stb,
   input  logic        i_m1_cyc,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_we,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_stb,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_ack,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
   localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] WD_LIM = CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic           r_last, last_nxt;
   logic [CW-1:0]  wd_cnt, wd_cnt_nxt;
   logic           gnt_stb;
   logic           wd_expire;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state  <= IDLE;
         r_last <= 1'b1;
         wd_cnt <= '0;
      end else begin
         state  <= state_nxt;
         r_last <= last_nxt;
         wd_cnt <= wd_cnt_nxt;
      end
   end

   // Next state: round-robin only decides from IDLE; a tenure ends on cyc fall.
   always_comb begin
      state_nxt = state;
      last_nxt  = r_last;
      case (state)
         IDLE: begin
            if (i_m0_cyc && (!i_m1_cyc || r_last)) begin
               state_nxt = GNT0;
               last_nxt  = 1'b0;
            end else if (i_m1_cyc) begin
               state_nxt = GNT1;
               last_nxt  = 1'b1;
            end
         end
         GNT0:    if (!i_m0_cyc) state_nxt = IDLE;
         GNT1:    if (!i_m1_cyc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_wb_adr = '0;
      o_wb_dat = '0;
      o_wb_we  = 1'b0;
      o_wb_sel = '0;
      o_wb_stb = 1'b0;
      o_wb_cyc = 1'b0;
      o_grant  = 2'b00;
      gnt_stb  = 1'b0;
      case (state)
         GNT0: begin
            o_wb_adr = i_m0_adr;
            o_wb_dat = i_m0_dat;
            o_wb_we  = i_m0_we;
            o_wb_sel = i_m0_sel;
            o_wb_stb = i_m0_stb;
            o_wb_cyc = i_m0_cyc;
            o_grant  = 2'b01;
            gnt_stb  = i_m0_stb;
         end
         GNT1: begin
            o_wb_adr = i_m1_adr;
            o_wb_dat = i_m1_dat;
            o_wb_we  = i_m1_we;
            o_wb_sel = i_m1_sel;
            o_wb_stb = i_m1_stb;
            o_wb_cyc = i_m1_cyc;
            o_grant  = 2'b10;
            gnt_stb  = i_m1_stb;
         end
         default: ;
      endcase
   end

   // Ack wins over a coinciding expiry; any ack or stb gap restarts the count.
   always_comb begin
      wd_expire  = 1'b0;
      wd_cnt_nxt = '0;
      if (WD_EN && state != IDLE && gnt_stb && !i_wb_ack) begin
         if (wd_cnt == WD_LIM)
            wd_expire = 1'b1;
         else
            wd_cnt_nxt = wd_cnt + 1'b1;
      end
   end

   assign o_m0_ack  = (state == GNT0) && i_wb_ack;
   assign o_m1_ack  = (state == GNT1) && i_wb_ack;
   assign o_m0_err  = (state == GNT0) && wd_expire;
   assign o_m1_err  = (state == GNT1) && wd_expire;
   assign o_timeout = wd_expire;

   // Read data is shared; masters qualify it with their own ack.
   assign o_m0_dat = i_wb_dat;
   assign o_m1_dat = i_wb_dat;

endmodule

// File: tb/tb_wb_master_arb.sv
// Directed bench for wb_master_arb: watchdog of 4 on the main instance and a
// watchdog-disabled instance sharing the same stimulus.
module tb_wb_master_arb;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, wb_rdat;
   logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, wb_ack;
   logic [3:0]  m0_sel, m1_sel;

   logic [31:0] o_m0_dat, o_m1_dat, o_wb_adr, o_wb_dat;
   logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
   logic        o_wb_we, o_wb_stb, o_wb_cyc, o_timeout;
   logic [3:0]  o_wb_sel;
   logic [1:0]  o_grant;

   logic [31:0] z_m0_dat, z_m1_dat, z_wb_adr, z_wb_dat;
   logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
   logic        z_wb_we, z_wb_stb, z_wb_cyc, z_timeout;
   logic [3:0]  z_wb_sel;
   logic [1:0]  z_grant;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   wb_master_arb #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .o_m0_dat(o_m0_dat), .i_m0_we(m0_we),
      .i_m0_sel(m0_sel), .i_m0_stb(m0_stb), .i_m0_cyc(m0_cyc),
      .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
      .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .o_m1_dat(o_m1_dat), .i_m1_we(m1_we),
      .i_m1_sel(m1_sel), .i_m1_stb(m1_stb), .i_m1_cyc(m1_cyc),
      .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
      .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
      .o_wb_stb(o_wb_stb), .o_wb_cyc(o_wb_cyc), .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   wb_master_arb #(.TIMEOUT_CYCLES(0)) dut_nowd (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .o_m0_dat(z_m0_dat), .i_m0_we(m0_we),
      .i_m0_sel(m0_sel), .i_m0_stb(m0_stb), .i_m0_cyc(m0_cyc),
      .o_m0_ack(z_m0_ack), .o_m0_err(z_m0_err),
      .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .o_m1_dat(z_m1_dat), .i_m1_we(m1_we),
      .i_m1_sel(m1_sel), .i_m1_stb(m1_stb), .i_m1_cyc(m1_cyc),
      .o_m1_ack(z_m1_ack), .o_m1_err(z_m1_err),
      .o_wb_adr(z_wb_adr), .o_wb_dat(z_wb_dat), .o_wb_we(z_wb_we), .o_wb_sel(z_wb_sel),
      .o_wb_stb(z_wb_stb), .o_wb_cyc(z_wb_cyc), .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack),
      .o_grant(z_grant), .o_timeout(z_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock and leave inputs/outputs settled away from the edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   int nerr;

   initial begin
      i_reset = 1'b1;
      m0_adr = '0; m0_dat = '0; m0_we = 0; m0_sel = '0; m0_stb = 0; m0_cyc = 0;
      m1_adr = '0; m1_dat = '0; m1_we = 0; m1_sel = '0; m1_stb = 0; m1_cyc = 0;
      wb_rdat = 32'h1234_5678; wb_ack = 0;
      step(); step();
      i_reset = 1'b0;
      settle();
      chk("rst_grant", 32'(o_grant), 32'h0);
      chk("rst_cyc", 32'(o_wb_cyc), 32'h0);
      chk("rst_timeout", 32'(o_timeout), 32'h0);
      chk("rst_acks", 32'({o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}), 32'h0);

      // single master write with one wait state
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0000_0010;
      m0_dat = 32'hDEAD_BEEF; m0_sel = 4'hF;
      settle();
      chk("single_pre_grant", 32'(o_grant), 32'h0);
      chk("single_pre_cyc", 32'(o_wb_cyc), 32'h0);
      step(); settle();
      chk("single_grant", 32'(o_grant), 32'h1);
      chk("single_adr", o_wb_adr, 32'h0000_0010);
      chk("single_dat", o_wb_dat, 32'hDEAD_BEEF);
      chk("single_ctl", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}), 32'h7F);
      chk("single_noack", 32'(o_m0_ack), 32'h0);
      step(); wb_ack = 1; settle();
      chk("single_ack0", 32'(o_m0_ack), 32'h1);
      chk("single_ack1", 32'(o_m1_ack), 32'h0);
      chk("single_rdat", o_m0_dat, 32'h1234_5678);
      step(); wb_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0; settle();
      chk("single_drop_ack", 32'(o_m0_ack), 32'h0);
      step(); settle();
      chk("single_idle", 32'(o_grant), 32'h0);

      // contention right after reset: m0 first, m1 after one IDLE cycle
      i_reset = 1; step(); i_reset = 0;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0020;
      step(); settle();
      chk("cont_first", 32'(o_grant), 32'h1);
      wb_ack = 1; settle();
      chk("cont_m0ack", 32'({o_m0_ack, o_m1_ack}), 32'h2);
      step(); wb_ack = 0; m0_cyc = 0; m0_stb = 0;
      step(); settle();
      chk("cont_turnaround", 32'(o_grant), 32'h0);
      step(); settle();
      chk("cont_second", 32'(o_grant), 32'h2);
      chk("cont_adr", o_wb_adr, 32'h0000_0020);
      wb_ack = 1; settle();
      chk("cont_m1ack", 32'({o_m0_ack, o_m1_ack}), 32'h1);
      step(); wb_ack = 0; m1_cyc = 0; m1_stb = 0;
      step();
      m0_cyc = 1; m1_cyc = 1;
      step(); settle();
      chk("cont_alt_m0", 32'(o_grant), 32'h1);
      m0_cyc = 0; m1_cyc = 0;
      step(); step();
      m0_cyc = 1; m1_cyc = 1;
      step(); settle();
      chk("cont_alt_m1", 32'(o_grant), 32'h2);
      m0_cyc = 0; m1_cyc = 0;
      step(); step();

      // cycle lock: m0 holds cyc across 3 acked strobes while m1 waits
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
      step(); settle();
      chk("lock_grant", 32'(o_grant), 32'h1);
      m1_cyc = 1; m1_stb = 1; wb_ack = 1;
      for (int i = 0; i < 3; i++) begin
         m0_adr = 32'h0000_0100 + 32'(4 * i);
         settle();
         chk($sformatf("lock_ack%0d", i), 32'({o_m0_ack, o_m1_ack}), 32'h2);
         chk($sformatf("lock_adr%0d", i), o_wb_adr, 32'h0000_0100 + 32'(4 * i));
         step();
      end
      settle();
      chk("lock_hold", 32'(o_grant), 32'h1);
      wb_ack = 0; m0_cyc = 0; m0_stb = 0;
      step(); settle();
      chk("lock_release", 32'(o_grant), 32'h0);
      step(); settle();
      chk("lock_handoff", 32'(o_grant), 32'h2);
      m1_cyc = 0; m1_stb = 0;
      step(); step();

      // watchdog: unacked m1 strobe expires on cycles 4 and 8
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'hF000_0000;
      step();
      for (int i = 1; i <= 8; i++) begin
         settle();
         chk($sformatf("wd_err_c%0d", i), 32'({o_m1_err, o_timeout, o_m0_err}),
             (i % 4 == 0) ? 32'h6 : 32'h0);
         step();
      end
      m1_cyc = 0; m1_stb = 0;
      step(); step();

      // ack on the would-be expiry cycle suppresses err and restarts count
      m1_cyc = 1; m1_stb = 1;
      step();
      for (int i = 1; i <= 8; i++) begin
         wb_ack = (i == 4);
         settle();
         if (i == 4)
            chk("wd_ackwin_ack", 32'(o_m1_ack), 32'h1);
         chk($sformatf("wd_ackwin_c%0d", i), 32'({o_m1_err, o_timeout}),
             (i == 8) ? 32'h3 : 32'h0);
         step();
      end
      wb_ack = 0;

      // watchdog disabled: 1000 unacked strobe cycles never error
      nerr = 0;
      for (int i = 0; i < 1000; i++) begin
         settle();
         if (z_m1_err || z_timeout) nerr++;
         step();
      end
      settle();
      chk("nowd_grant", 32'(z_grant), 32'h2);
      chk("nowd_errs", 32'(nerr), 32'h0);

      // reset mid-tenure with both masters requesting
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0040;
      settle();
      chk("rstmid_pre", 32'(o_grant), 32'h2);
      i_reset = 1;
      step(); settle();
      chk("rstmid_grant", 32'(o_grant), 32'h0);
      chk("rstmid_bus", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}), 32'h0);
      chk("rstmid_adr", o_wb_adr | o_wb_dat, 32'h0);
      i_reset = 0;
      step(); settle();
      chk("rstmid_m0first", 32'(o_grant), 32'h1);
      chk("rstmid_adr_m0", o_wb_adr, 32'h0000_0040);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout_guard got=running exp=finished");
      $fatal(1);
   end

endmodule
